// File: rtl/uart_tx_port_if.sv
// uart_tx_port_if: strobe-style register bus (mode select, read/write strobes, data) for uart_tx_port.
interface uart_tx_port_if;
  logic [1:0] mode;
  logic       read;
  logic       write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  modport master (output mode, read, write, data_in, input data_out);
  modport slave (input mode, read, write, data_in, output data_out);
endinterface

// File: rtl/uart_tx_port.sv
// uart_tx_port: strobe-bus UART transmitter with byte FIFO and programmable divisor, 8N1 frames.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop (8E1).
module uart_tx_port #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int DEFAULT_DIV = 546
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_port_if.slave bus,
  output logic          txd,
  output logic          tx_irq
);
  localparam int N = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << N;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t      state_q, state_d;
  logic        read_dly_q, write_dly_q;
  logic [7:0]  mem_q [DEPTH];
  logic [N:0]  wp_q, rp_q, count;
  logic        overflow_q, ovf_hold_q;
  logic [15:0] div_q, bit_div_q, bit_div_d, baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d, irq_q, irq_d;
  logic        wr_edge, rd_edge, push, pop, full, empty, bit_end;
  logic [15:0] cnt_w;
  logic [3:0]  cnt_sat;
  logic [7:0]  status;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif
  assign wr_edge = bus.write && !write_dly_q;
  assign rd_edge = bus.read && !read_dly_q;
  assign count = wp_q - rp_q;
  assign full = count[N];
  assign empty = count == '0;
  assign push = wr_edge && bus.mode == 2'd0 && !full;
  assign bit_end = baud_q == bit_div_q;
  assign cnt_w = 16'(count);
  assign cnt_sat = cnt_w > 16'd15 ? 4'hF : cnt_w[3:0];
  // bit0 reads as "space available", so an empty idle FIFO reports 0x03
  assign status = {cnt_sat, overflow_q || ovf_hold_q, state_q != IDLE, empty, !full};
  assign bus.data_out = bus.mode == 2'd1 ? status :
                        bus.mode == 2'd2 ? div_q[7:0] :
                        bus.mode == 2'd3 ? div_q[15:8] : 8'h00;
  assign txd = txd_q;
  assign tx_irq = irq_q;
  always_comb begin
    state_d = state_q;
    baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d = shift_q;
    bit_div_d = bit_div_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        pop = !empty;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
        if (bit_idx_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (bit_end) state_d = STOP;
`else
        if (bit_idx_q == 3'd7) state_d = STOP;
      end
`endif
      STOP: if (bit_end) begin
        state_d = IDLE;
        pop = !empty;
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      shift_d = mem_q[rp_q[N-1:0]];
      bit_div_d = div_q;
      bit_idx_d = 3'd0;
      baud_d = 16'd0;
    end
  end
`ifdef UART_TX_PARITY_EN
  assign txd_d = state_q == PARITY ? par_q : state_q == DATA ? shift_q[0] : state_q != START;
`else
  assign txd_d = state_q == DATA ? shift_q[0] : state_q != START;
`endif
  assign irq_d = empty && state_d == IDLE;
  always_ff @(posedge clk) if (push) mem_q[wp_q[N-1:0]] <= bus.data_in;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      read_dly_q <= 1'b0;
      write_dly_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      overflow_q <= 1'b0;
      ovf_hold_q <= 1'b0;
      div_q <= 16'(DEFAULT_DIV);
      bit_div_q <= 16'(DEFAULT_DIV);
      baud_q <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q <= 8'd0;
      txd_q <= 1'b1;
      irq_q <= 1'b1;
    end else begin
      state_q <= state_d;
      read_dly_q <= bus.read;
      write_dly_q <= bus.write;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
      overflow_q <= (wr_edge && bus.mode == 2'd0 && full) ? 1'b1 :
                    (rd_edge && bus.mode == 2'd1) ? 1'b0 : overflow_q;
      // keep showing overflow for the rest of the read that cleared it
      ovf_hold_q <= bus.read && (ovf_hold_q || (rd_edge && bus.mode == 2'd1 && overflow_q));
      if (wr_edge && bus.mode == 2'd2) div_q[7:0] <= bus.data_in;
      if (wr_edge && bus.mode == 2'd3) div_q[15:8] <= bus.data_in;
      bit_div_q <= bit_div_d;
      baud_q <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q <= shift_d;
      txd_q <= txd_d;
      irq_q <= irq_d;
    end
  end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_q <= 1'b0;
    else if (pop) par_q <= ^shift_d;
  end
`endif
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed self-checking bench for uart_tx_port; txd/tx_irq history is recorded per clock.
module tb_uart_tx_port;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic txd, tx_irq;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic hist_txd [0:8191];
  logic hist_irq [0:8191];
  uart_tx_port_if bus();
  uart_tx_port dut (.clk(clk), .reset(reset), .bus(bus), .txd(txd), .tx_irq(tx_irq));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (cyc < 8192) begin
    hist_txd[cyc] = txd;
    hist_irq[cyc] = tx_irq;
  end
  // expected line level for bit k of a frame: start, 8 data LSB first, [parity], stop
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && NB == 11) return ^b;
    return 1'b1;
  endfunction
  task automatic bus_write(input logic [1:0] m, input logic [7:0] d, output int e);
    bus.mode = m;
    bus.data_in = d;
    bus.write = 1'b1;
    e = cyc + 1;
    repeat (4) @(negedge clk);
    bus.write = 1'b0;
    @(negedge clk);
  endtask
  task automatic bus_read(input logic [1:0] m, output logic [7:0] d);
    bus.mode = m;
    bus.read = 1'b1;
    repeat (2) @(negedge clk);
    d = bus.data_out;
    bus.read = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    logic [7:0] d;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.mode = 2'd0;
    bus.data_in = 8'd0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd); else passed++;
    total++; if (tx_irq !== 1'b1) $display("FAIL reset_irq: got %b expected 1", tx_irq); else passed++;
    reset = 1'b1;
    @(negedge clk);
    bus_read(2'd1, d);
    total++; if (d !== 8'h03) $display("FAIL reset_status: got %h expected 03", d); else passed++;
    bus_read(2'd2, d);
    total++; if (d !== 8'h22) $display("FAIL reset_div_lo: got %h expected 22", d); else passed++;
    bus_read(2'd3, d);
    total++; if (d !== 8'h02) $display("FAIL reset_div_hi: got %h expected 02", d); else passed++;
    bus_read(2'd0, d);
    total++; if (d !== 8'h00) $display("FAIL read_data_reg: got %h expected 00", d); else passed++;
  endtask
  task automatic test_single_frame();
    int e, ex;
    bus_write(2'd2, 8'd3, ex);
    bus_write(2'd3, 8'd0, ex);
    bus_write(2'd0, 8'h55, e);
    while (cyc < e + 4 * NB + 12) @(negedge clk);
    total++; if (hist_txd[e+1] !== 1'b1) $display("FAIL single_pre_start: got %b expected 1", hist_txd[e+1]); else passed++;
    total++; if (hist_irq[e] !== 1'b1) $display("FAIL single_irq_at_e: got %b expected 1", hist_irq[e]); else passed++;
    total++; if (hist_irq[e+1] !== 1'b0) $display("FAIL single_irq_fall: got %b expected 0", hist_irq[e+1]); else passed++;
    for (int k = 0; k < NB; k++)
      for (int c = 0; c < 4; c++) begin
        total++;
        if (hist_txd[e+2+4*k+c] !== exp_bit(8'h55, k))
          $display("FAIL single_bit%0d_clk%0d: got %b expected %b", k, c, hist_txd[e+2+4*k+c], exp_bit(8'h55, k));
        else passed++;
      end
    total++; if (hist_irq[e+4*NB] !== 1'b0) $display("FAIL single_irq_in_stop: got %b expected 0", hist_irq[e+4*NB]); else passed++;
    total++; if (hist_irq[e+1+4*NB] !== 1'b1) $display("FAIL single_irq_rise: got %b expected 1", hist_irq[e+1+4*NB]); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (hist_txd[e+2+4*NB+i] !== 1'b1) $display("FAIL single_idle_after_%0d: got %b expected 1", i, hist_txd[e+2+4*NB+i]);
      else passed++;
    end
  endtask
  task automatic test_overflow_back_to_back();
    int e1, ex, base;
    logic [7:0] d;
    bus_write(2'd2, 8'd200, ex);
    bus_write(2'd3, 8'd0, ex);
    bus_write(2'd0, 8'h80, e1);
    for (int i = 1; i <= 17; i++) bus_write(2'd0, 8'(8'h80 + i), ex);
    bus_read(2'd1, d);
    total++; if (d !== 8'hFC) $display("FAIL ovf_status_set: got %h expected FC", d); else passed++;
    bus_read(2'd1, d);
    total++; if (d !== 8'hF4) $display("FAIL ovf_status_clear: got %h expected F4", d); else passed++;
    bus_write(2'd2, 8'd0, ex);
    base = e1 + 2 + 201 * NB;
    total++; if (cyc >= base) $display("FAIL ovf_setup_slow: cycle %0d required below %0d", cyc, base); else passed++;
    while (cyc < base + 16 * NB + 10) @(negedge clk);
    for (int f = 0; f < 16; f++)
      for (int k = 0; k < NB; k++) begin
        total++;
        if (hist_txd[base+f*NB+k] !== exp_bit(8'(8'h81 + f), k))
          $display("FAIL b2b_frame%0d_bit%0d: got %b expected %b", f, k, hist_txd[base+f*NB+k], exp_bit(8'(8'h81 + f), k));
        else passed++;
      end
    total++; if (hist_irq[base+16*NB-2] !== 1'b0) $display("FAIL b2b_irq_last_stop: got %b expected 0", hist_irq[base+16*NB-2]); else passed++;
    total++; if (hist_irq[base+16*NB-1] !== 1'b1) $display("FAIL b2b_irq_rise: got %b expected 1", hist_irq[base+16*NB-1]); else passed++;
    total++; if (hist_txd[base+16*NB+5] !== 1'b1) $display("FAIL b2b_no_17th: got %b expected 1", hist_txd[base+16*NB+5]); else passed++;
  endtask
  task automatic test_div_change();
    int e, ex, base;
    bus_write(2'd2, 8'd3, ex);
    bus_write(2'd0, 8'hA0, e);
    bus_write(2'd2, 8'd9, ex);
    bus_write(2'd0, 8'h3C, ex);
    base = e + 2 + 4 * NB;
    while (cyc < base + 10 * NB + 5) @(negedge clk);
    for (int k = 0; k < NB; k++)
      for (int c = 0; c < 4; c++) begin
        total++;
        if (hist_txd[e+2+4*k+c] !== exp_bit(8'hA0, k))
          $display("FAIL div_old_bit%0d_clk%0d: got %b expected %b", k, c, hist_txd[e+2+4*k+c], exp_bit(8'hA0, k));
        else passed++;
      end
    for (int k = 0; k < NB; k++)
      for (int c = 0; c < 10; c++) begin
        total++;
        if (hist_txd[base+10*k+c] !== exp_bit(8'h3C, k))
          $display("FAIL div_new_bit%0d_clk%0d: got %b expected %b", k, c, hist_txd[base+10*k+c], exp_bit(8'h3C, k));
        else passed++;
      end
  endtask
  task automatic test_reset_midframe();
    int e, ex, s, zeros;
    logic [7:0] d;
    bus_write(2'd2, 8'd3, ex);
    bus_write(2'd0, 8'hA5, e);
    bus_write(2'd0, 8'h01, ex);
    bus_write(2'd0, 8'h02, ex);
    bus_write(2'd0, 8'h03, ex);
    while (cyc < e + 22) @(negedge clk);
    total++; if (txd !== exp_bit(8'hA5, 5)) $display("FAIL midframe_pre: got %b expected %b", txd, exp_bit(8'hA5, 5)); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (txd !== 1'b1) $display("FAIL midframe_txd_async: got %b expected 1", txd); else passed++;
    total++; if (tx_irq !== 1'b1) $display("FAIL midframe_irq_async: got %b expected 1", tx_irq); else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus_read(2'd1, d);
    total++; if (d !== 8'h03) $display("FAIL midframe_status: got %h expected 03", d); else passed++;
    s = cyc;
    while (cyc < s + 60) @(negedge clk);
    zeros = 0;
    for (int i = s; i < s + 60; i++) if (hist_txd[i] !== 1'b1) zeros++;
    total++; if (zeros != 0) $display("FAIL midframe_no_frames: got %0d low clocks expected 0", zeros); else passed++;
  endtask
`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int e, ex;
    bus_write(2'd2, 8'd3, ex);
    bus_write(2'd0, 8'h07, e);
    while (cyc < e + 50) @(negedge clk);
    total++; if (hist_txd[e+2+36] !== 1'b1) $display("FAIL parity_07: got %b expected 1", hist_txd[e+2+36]); else passed++;
    total++; if (hist_txd[e+2+40] !== 1'b1) $display("FAIL parity_07_stop: got %b expected 1", hist_txd[e+2+40]); else passed++;
    total++; if (hist_irq[e+44] !== 1'b0) $display("FAIL parity_len_stop: got %b expected 0", hist_irq[e+44]); else passed++;
    total++; if (hist_irq[e+45] !== 1'b1) $display("FAIL parity_len_end: got %b expected 1", hist_irq[e+45]); else passed++;
    bus_write(2'd0, 8'h03, e);
    while (cyc < e + 50) @(negedge clk);
    total++; if (hist_txd[e+2+36] !== 1'b0) $display("FAIL parity_03: got %b expected 0", hist_txd[e+2+36]); else passed++;
  endtask
`endif
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single_frame();
    test_overflow_back_to_back();
    test_div_change();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
